digit_serial_add_seq: RTL

//  Digit-serial sequencer for W-bit addition over the team's 2-bit adder slice.
//  - Sits directly upstream and downstream of the slice:
//    - accepts a W-bit operand pair on a valid/ready handshake;
//    - feeds one 2-bit digit per cycle to the slice, LSB digit first;
//    - registers the slice carry between digits;
//    - assembles the W-bit sum and carry-out behind a second valid/ready handshake.
//  The slice is purely combinational: {DCO,DS} = DA + DB + DCI in the same cycle.

---
 rtl/digit_serial_add_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/digit_serial_add_seq.sv
// Digit-serial sequencer that walks a W-bit addition through an external
// combinational 2-bit adder slice, one digit per cycle, LSB digit first.
module digit_serial_add_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [1:0]   da,
  output logic [1:0]   db,
  output logic         dci,
  input  logic [1:0]   ds,
  input  logic         dco,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  localparam int NDIG = W / 2;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [W-1:0]   a_sh_r;
  logic [W-1:0]   b_sh_r;
  logic [W-1:0]   sum_sh_r;
  logic [W-1:0]   sum_shift_s;
  logic           carry_r;
  logic [CW-1:0]  cnt_r;

  // Digit sums enter at the MSB end so the first (LSB) digit ends up at bit 0.
  generate
    if (W == 2) begin : g_single_digit
      assign sum_shift_s = ds;
    end else begin : g_multi_digit
      assign sum_shift_s = {ds, sum_sh_r[W-1:2]};
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_DIG) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand shifters, carry, digit counter and sum assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      sum_sh_r <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            carry_r <= cin;
            cnt_r   <= '0;
          end
        end
        RUN: begin
          sum_sh_r <= sum_shift_s;
          carry_r  <= dco;
          a_sh_r   <= a_sh_r >> 2'd2;
          b_sh_r   <= b_sh_r >> 2'd2;
          cnt_r    <= cnt_r + 1'b1;
        end
        DONE: begin
          sum_sh_r <= sum_sh_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only; slice drive is gated to RUN
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    da        = 2'b00;
    db        = 2'b00;
    dci       = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
      end
      RUN: begin
        busy = 1'b1;
        da   = a_sh_r[1:0];
        db   = b_sh_r[1:0];
        dci  = carry_r;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign sum  = sum_sh_r;
  assign cout = carry_r;

endmodule
